// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and width helper for the LIF spike generator
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } lif_state_e;

    localparam int N_STAGE_DEF = 6;

    // Datapath width matches the membrane-potential accumulator: N_STAGE + 2.
    function automatic int lif_width(input int n_stage);
        return n_stage + 2;
    endfunction

    localparam int W_DEF = lif_width(N_STAGE_DEF);

endpackage

// File: rtl/lif_decay.sv
// rtl/lif_decay.sv - shift-subtract leak with refractory clamp
module lif_decay
    import lif_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic signed [W-1:0] u,
    input  logic        [2:0]   beta_shift,
    input  logic                clamp,
    output logic        [W-1:0] beta_u
);

    logic signed [W-1:0] leak;

    // beta*u = u - u*2^-shift; shift 0 leaks everything, refractory forces zero
    always_comb begin
        leak   = u >>> beta_shift;
        beta_u = clamp ? '0 : (u - leak);
    end

endmodule

// File: rtl/lif_spike_gen.sv
// rtl/lif_spike_gen.sv - LIF threshold compare, decay, refractory and spike counting
module lif_spike_gen
    import lif_pkg::*;
#(
    parameter int N_STAGE  = 6,
    parameter int REFRAC_W = 4,
    parameter int CNT_W    = 8,
    localparam int W       = lif_width(N_STAGE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        u_in,
    input  logic                u_valid,
    output logic                u_ready,
    input  logic [W-1:0]        theta,
    input  logic [2:0]          beta_shift,
    input  logic [REFRAC_W-1:0] refrac_len,
    input  logic                cnt_clr,
    output logic [W-1:0]        beta_u,
    output logic [W-1:0]        minus_teta,
    output logic                was_spike,
    output logic                spike,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    spike_cnt
);

    lif_state_e state_q, state_d;

    logic [W-1:0]        u_q, theta_q;
    logic [2:0]          shift_q;
    logic [REFRAC_W-1:0] rlen_q, refrac_q, refrac_d;
    logic [W-1:0]        beta_u_q, minus_teta_q;
    logic                was_spike_q, spike_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept, in_calc, refractory, ge_thr, spike_now;
    logic signed [W:0]   u_ext, theta_ext;
    logic [W-1:0]        decay_beta;

    assign accept     = (state_q == IDLE) && u_valid;
    assign in_calc    = (state_q == CALC);
    assign refractory = (refrac_q != '0);
    // Theta is unsigned, so widen by one bit to compare it against signed u.
    assign u_ext      = {u_q[W-1], u_q};
    assign theta_ext  = {1'b0, theta_q};
    assign ge_thr     = (u_ext >= theta_ext);
    assign spike_now  = ge_thr && !refractory;

    lif_decay #(.W(W)) u_decay (
        .u          (u_q),
        .beta_shift (shift_q),
        .clamp      (refractory),
        .beta_u     (decay_beta)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one accept, one evaluate cycle, then hold until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (u_valid)   state_d = CALC;
            CALC:                   state_d = EMIT;
            EMIT:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        u_ready   = (state_q == IDLE);
        out_valid = (state_q == EMIT);
    end

    // Refractory and saturating counter next-state; clear wins but keeps a same-cycle spike
    always_comb begin
        refrac_d = refrac_q;
        if (in_calc) begin
            if (spike_now)       refrac_d = rlen_q;
            else if (refractory) refrac_d = refrac_q - 1'b1;
        end
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = (in_calc && spike_now) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        else if (in_calc && spike_now && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Capture inputs at accept; register timestep results at CALC, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_q          <= '0;
            theta_q      <= '0;
            shift_q      <= '0;
            rlen_q       <= '0;
            beta_u_q     <= '0;
            minus_teta_q <= '0;
            was_spike_q  <= 1'b0;
            spike_q      <= 1'b0;
            refrac_q     <= '0;
            cnt_q        <= '0;
        end else begin
            refrac_q <= refrac_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                u_q     <= u_in;
                theta_q <= theta;
                shift_q <= beta_shift;
                rlen_q  <= refrac_len;
            end
            if (in_calc) begin
                beta_u_q     <= decay_beta;
                minus_teta_q <= spike_now ? ('0 - theta_q) : '0;
                was_spike_q  <= spike_now;
                spike_q      <= spike_now;
            end
        end
    end

    assign beta_u     = beta_u_q;
    assign minus_teta = minus_teta_q;
    assign was_spike  = was_spike_q;
    assign spike      = spike_q;
    assign spike_cnt  = cnt_q;

endmodule

// File: tb/tb_lif_spike_gen.sv
// tb/tb_lif_spike_gen.sv - directed self-checking bench for lif_spike_gen
module tb_lif_spike_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] u_in, theta;
    logic       u_valid;
    logic [2:0] beta_shift;
    logic [3:0] refrac_len;
    logic       cnt_clr, out_ready;
    logic       u_ready, was_spike, spike, out_valid;
    logic [7:0] beta_u, minus_teta, spike_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    lif_spike_gen #(.N_STAGE(6), .REFRAC_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .u_in       (u_in),
        .u_valid    (u_valid),
        .u_ready    (u_ready),
        .theta      (theta),
        .beta_shift (beta_shift),
        .refrac_len (refrac_len),
        .cnt_clr    (cnt_clr),
        .beta_u     (beta_u),
        .minus_teta (minus_teta),
        .was_spike  (was_spike),
        .spike      (spike),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .spike_cnt  (spike_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one timestep and advance to the EMIT cycle; config is scrambled after accept.
    task automatic send(input logic [7:0] u, input logic [7:0] th, input logic [2:0] sh,
                        input logic [3:0] rl, input logic clr);
        int n;
        n = 0;
        while (u_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("u_ready_before_accept", {31'd0, u_ready}, 32'd1);
        u_in = u; theta = th; beta_shift = sh; refrac_len = rl; u_valid = 1'b1;
        @(negedge clk);
        u_valid = 1'b0;
        u_in = 8'h80; theta = 8'h7F; beta_shift = 3'd7; refrac_len = 4'hF;
        check_eq("calc_u_ready", {31'd0, u_ready}, 32'd0);
        check_eq("calc_out_valid", {31'd0, out_valid}, 32'd0);
        cnt_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        check_eq("emit_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("emit_u_ready", {31'd0, u_ready}, 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [7:0] th, input logic exp_spk,
                             input logic [7:0] exp_beta, input logic clr);
        logic [7:0] exp_mt;
        exp_mt = exp_spk ? (8'd0 - th) : 8'd0;
        if (clr) exp_cnt = exp_spk ? 1 : 0;
        else if (exp_spk && exp_cnt < 255) exp_cnt++;
        check_eq({tag, ":spike"},      {31'd0, spike},      {31'd0, exp_spk});
        check_eq({tag, ":was_spike"},  {31'd0, was_spike},  {31'd0, exp_spk});
        check_eq({tag, ":beta_u"},     {24'd0, beta_u},     {24'd0, exp_beta});
        check_eq({tag, ":minus_teta"}, {24'd0, minus_teta}, {24'd0, exp_mt});
        check_eq({tag, ":spike_cnt"},  {24'd0, spike_cnt},  exp_cnt);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ":idle_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ":idle_u_ready"},   {31'd0, u_ready},   32'd1);
    endtask

    task automatic step(input string tag, input logic [7:0] u, input logic [7:0] th,
                        input logic [2:0] sh, input logic [3:0] rl,
                        input logic exp_spk, input logic [7:0] exp_beta);
        send(u, th, sh, rl, 1'b0);
        check_res(tag, th, exp_spk, exp_beta, 1'b0);
        consume(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s_beta, s_mt, s_cnt;
        logic       s_spk;

        rst_n = 1'b0; u_in = '0; theta = '0; u_valid = 1'b0; beta_shift = '0;
        refrac_len = '0; cnt_clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst:out_valid",  {31'd0, out_valid},  32'd0);
        check_eq("rst:spike",      {31'd0, spike},      32'd0);
        check_eq("rst:beta_u",     {24'd0, beta_u},     32'd0);
        check_eq("rst:minus_teta", {24'd0, minus_teta}, 32'd0);
        check_eq("rst:was_spike",  {31'd0, was_spike},  32'd0);
        check_eq("rst:spike_cnt",  {24'd0, spike_cnt},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst:u_ready", {31'd0, u_ready}, 32'd1);

        step("spike",      8'd50,  8'd40,  3'd1, 4'd0, 1'b1, 8'd25);
        step("sub",        8'd39,  8'd40,  3'd2, 4'd0, 1'b0, 8'd30);
        step("neg",        8'hEC,  8'd40,  3'd2, 4'd0, 1'b0, 8'hF1);
        step("shift0",     8'd10,  8'd40,  3'd0, 4'd0, 1'b0, 8'd0);
        step("eq_thr",     8'd40,  8'd40,  3'd3, 4'd0, 1'b1, 8'd35);
        step("signed_cmp", 8'hFF,  8'd0,   3'd1, 4'd0, 1'b0, 8'd0);
        step("max_thr",    8'd127, 8'd127, 3'd1, 4'd0, 1'b1, 8'd64);

        step("ref0",   8'd100, 8'd40, 3'd1, 4'd2, 1'b1, 8'd50);
        step("ref1",   8'd100, 8'd40, 3'd1, 4'd2, 1'b0, 8'd0);
        step("ref2",   8'd100, 8'd40, 3'd1, 4'd2, 1'b0, 8'd0);
        step("ref3",   8'd100, 8'd40, 3'd1, 4'd2, 1'b1, 8'd50);
        step("drain1", 8'd0,   8'd40, 3'd1, 4'd0, 1'b0, 8'd0);
        step("drain2", 8'd0,   8'd40, 3'd1, 4'd0, 1'b0, 8'd0);

        send(8'd60, 8'd40, 3'd1, 4'd0, 1'b0);
        check_res("bp", 8'd40, 1'b1, 8'd30, 1'b0);
        s_beta = beta_u; s_mt = minus_teta; s_cnt = spike_cnt; s_spk = spike;
        for (int i = 0; i < 5; i++) begin
            u_in = 8'd100 + 8'(i);
            u_valid = (i % 2 == 0);
            @(negedge clk);
            check_eq("bp:out_valid",  {31'd0, out_valid},  32'd1);
            check_eq("bp:u_ready",    {31'd0, u_ready},    32'd0);
            check_eq("bp:spike",      {31'd0, spike},      {31'd0, s_spk});
            check_eq("bp:beta_u",     {24'd0, beta_u},     {24'd0, s_beta});
            check_eq("bp:minus_teta", {24'd0, minus_teta}, {24'd0, s_mt});
            check_eq("bp:spike_cnt",  {24'd0, spike_cnt},  {24'd0, s_cnt});
        end
        u_valid = 1'b0;
        consume("bp");
        check_eq("bp:hold_beta_u",    {24'd0, beta_u},   32'd30);
        check_eq("bp:hold_was_spike", {31'd0, was_spike}, 32'd1);
        @(negedge clk);
        check_eq("bp:no_capture", {31'd0, out_valid}, 32'd0);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check_eq("clr_idle:spike_cnt", {24'd0, spike_cnt}, 32'd0);

        for (int i = 0; i < 255; i++) step("fill", 8'd100, 8'd40, 3'd1, 4'd0, 1'b1, 8'd50);
        check_eq("sat:full", {24'd0, spike_cnt}, 32'd255);
        step("sat_hold", 8'd100, 8'd40, 3'd1, 4'd0, 1'b1, 8'd50);

        send(8'd100, 8'd40, 3'd1, 4'd0, 1'b1);
        check_res("clr_spike", 8'd40, 1'b1, 8'd50, 1'b1);
        consume("clr_spike");

        u_in = 8'd50; theta = 8'd40; beta_shift = 3'd1; refrac_len = 4'd0; u_valid = 1'b1;
        @(negedge clk);
        u_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_calc:out_valid",  {31'd0, out_valid},  32'd0);
        check_eq("rst_calc:spike",      {31'd0, spike},      32'd0);
        check_eq("rst_calc:was_spike",  {31'd0, was_spike},  32'd0);
        check_eq("rst_calc:beta_u",     {24'd0, beta_u},     32'd0);
        check_eq("rst_calc:minus_teta", {24'd0, minus_teta}, 32'd0);
        check_eq("rst_calc:spike_cnt",  {24'd0, spike_cnt},  32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rel:u_ready",   {31'd0, u_ready},   32'd1);
        check_eq("rst_rel:out_valid", {31'd0, out_valid}, 32'd0);
        step("post_rst", 8'd50, 8'd40, 3'd1, 4'd0, 1'b1, 8'd25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
